// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - gcd engine with selectable subtractive Euclid or binary Stein iteration
module gcd_engine #(
    parameter int WIDTH = 32,
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] cycles,
    output logic             busy
);

    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, a_nx;
    logic [WIDTH-1:0] b_q, b_nx;
    logic [WIDTH-1:0] res_q, res_nx;
    logic [KW-1:0]    k_q, k_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            k_q   <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nx;
            a_q   <= a_nx;
            b_q   <= b_nx;
            res_q <= res_nx;
            k_q   <= k_nx;
            cnt_q <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        a_nx     = a_q;
        b_nx     = b_q;
        res_nx   = res_q;
        k_nx     = k_q;
        cnt_nx   = cnt_q;
        if (clear) begin
            // abort keeps result/cycles so the last reported values stay visible
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_nx   = a_in;
                        b_nx   = b_in;
                        k_nx   = '0;
                        cnt_nx = '0;
                        if (a_in == '0 || b_in == '0) begin
                            res_nx   = a_in | b_in;
                            state_nx = DONE;
                        end else begin
                            state_nx = CALC;
                        end
                    end
                end
                CALC: begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_nx = cnt_q + 1'b1;
                    end
                    if (a_q == b_q) begin
                        res_nx   = (MODE == 0) ? a_q : (a_q << k_q);
                        state_nx = DONE;
                    end else if (MODE != 0 && !a_q[0] && !b_q[0]) begin
                        a_nx = a_q >> 1;
                        b_nx = b_q >> 1;
                        k_nx = k_q + 1'b1;
                    end else if (MODE != 0 && !a_q[0]) begin
                        a_nx = a_q >> 1;
                    end else if (MODE != 0 && !b_q[0]) begin
                        b_nx = b_q >> 1;
                    end else if (a_q > b_q) begin
                        a_nx = a_q - b_q;
                    end else begin
                        b_nx = b_q - a_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC) || (state == DONE);
    assign result    = res_q;
    assign cycles    = cnt_q;

endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - scoreboard bench for gcd_engine in both modes and with a narrow counter
module tb_gcd_engine;

    typedef struct {
        logic [15:0] r;
        logic [15:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr[3];
    logic        iv[3];
    logic        ordy[3];
    logic [15:0] ain[3];
    logic [15:0] bin[3];

    logic        ov0, ov1, ov2, ir0, ir1, ir2, bz0, bz1, bz2;
    logic [15:0] r0, r1, c0, c1;
    logic [7:0]  r2;
    logic [3:0]  c2;

    logic        ov[3];
    logic        ir[3];
    logic        bz[3];
    logic [15:0] rs[3];
    logic [15:0] cy[3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int  n_vec = 0;
    int  n_err = 0;
    bit  rnd_ready = 1'b0;

    always #5 clk = ~clk;

    gcd_engine #(.WIDTH(16), .MODE(0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clr[0]), .in_valid(iv[0]), .in_ready(ir0),
        .a_in(ain[0]), .b_in(bin[0]), .out_valid(ov0), .out_ready(ordy[0]),
        .result(r0), .cycles(c0), .busy(bz0));

    gcd_engine #(.WIDTH(16), .MODE(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clr[1]), .in_valid(iv[1]), .in_ready(ir1),
        .a_in(ain[1]), .b_in(bin[1]), .out_valid(ov1), .out_ready(ordy[1]),
        .result(r1), .cycles(c1), .busy(bz1));

    gcd_engine #(.WIDTH(8), .MODE(0), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clr[2]), .in_valid(iv[2]), .in_ready(ir2),
        .a_in(ain[2][7:0]), .b_in(bin[2][7:0]), .out_valid(ov2), .out_ready(ordy[2]),
        .result(r2), .cycles(c2), .busy(bz2));

    always_comb begin
        ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
        ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
        bz[0] = bz0; bz[1] = bz1; bz[2] = bz2;
        rs[0] = r0;  rs[1] = r1;  rs[2] = {8'h00, r2};
        cy[0] = c0;  cy[1] = c1;  cy[2] = {12'h000, c2};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: gcd by remainder division; Euclid step count is the sum of quotients,
    // Stein step count follows the listed priority rules.
    function automatic exp_t model(input int i, input logic [15:0] a, input logic [15:0] b);
        exp_t    e;
        longint  x, y, t, n, k, cmax;
        cmax = (i == 2) ? 15 : 65535;
        x = a; y = b; n = 0;
        if (a == 0 || b == 0) begin
            e.r = a | b;
            e.c = 0;
            return e;
        end
        while (y != 0) begin
            if (i != 1) n += x / y;
            t = x % y; x = y; y = t;
        end
        e.r = x[15:0];
        if (i == 1) begin
            x = a; y = b; k = 0; n = 0;
            forever begin
                n++;
                if (x == y) break;
                if (x % 2 == 0 && y % 2 == 0) begin x /= 2; y /= 2; k++; end
                else if (x % 2 == 0) x /= 2;
                else if (y % 2 == 0) y /= 2;
                else if (x > y) x -= y;
                else y -= x;
            end
        end
        e.c = (n > cmax) ? cmax[15:0] : n[15:0];
        return e;
    endfunction

    task automatic sb_push(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int i, output exp_t e, output bit ok);
        ok = 1'b0;
        e.r = '0; e.c = '0;
        case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   ok;
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (ov[i] && ordy[i] && !clr[i]) begin
                    sb_pop(i, e, ok);
                    if (!ok) begin
                        chk($sformatf("sb_unexpected_valid%0d", i), ov[i], 0);
                    end else begin
                        chk($sformatf("sb_result%0d", i), rs[i], e.r);
                        chk($sformatf("sb_cycles%0d", i), cy[i], e.c);
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_ready) begin
            for (int i = 0; i < 3; i++) ordy[i] = ($urandom % 4) != 0;
        end
    end

    task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b, input bit push);
        int t = 0;
        @(negedge clk);
        while (!ir[i] && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!ir[i]) begin
            chk($sformatf("in_ready_timeout%0d", i), ir[i], 1);
            return;
        end
        ain[i] = a;
        bin[i] = b;
        iv[i]  = 1'b1;
        if (push) sb_push(i, model(i, a, b));
        @(posedge clk);
        #1 iv[i] = 1'b0;
    endtask

    task automatic wait_ov(input int i, output int n);
        n = 0;
        while (!ov[i] && n < 5000) begin
            @(posedge clk);
            #1 n++;
        end
        if (!ov[i]) chk($sformatf("out_valid_timeout%0d", i), ov[i], 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            clr[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b1; ain[i] = '0; bin[i] = '0;
        end
        #3;
        chk("rst_in_ready", ir[0], 1);
        chk("rst_out_valid", ov[0], 0);
        chk("rst_busy", bz[1], 0);
        chk("rst_result", rs[1], 0);
        chk("rst_cycles", cy[0], 0);
        @(negedge clk) rst_n = 1'b1;

        issue(0, 16'd12, 16'd8, 1);
        wait_ov(0, n);
        chk("m0_12_8_latency", n + 1, 4);
        chk("m0_12_8_result", rs[0], 4);
        chk("m0_12_8_cycles", cy[0], 3);

        issue(0, 16'd0, 16'd35, 1);
        wait_ov(0, n);
        chk("zero_35_latency", n + 1, 1);
        chk("zero_35_result", rs[0], 35);
        issue(0, 16'd0, 16'd0, 1);
        wait_ov(0, n);
        chk("zero_zero_latency", n + 1, 1);
        chk("zero_zero_result", rs[0], 0);

        issue(0, 16'd12, 16'd12, 1);
        wait_ov(0, n);
        chk("m0_equal_cycles", cy[0], 1);

        issue(1, 16'd12, 16'd8, 1);
        wait_ov(1, n);
        chk("m1_12_8_result", rs[1], 4);
        chk("m1_12_8_cycles", cy[1], 6);
        issue(1, 16'd48, 16'd18, 1);
        wait_ov(1, n);
        chk("m1_48_18_result", rs[1], 6);

        issue(2, 16'd255, 16'd1, 1);
        wait_ov(2, n);
        chk("sat_result", rs[2], 1);
        chk("sat_cycles", cy[2], 15);

        @(negedge clk) ordy[0] = 1'b0;
        issue(0, 16'd21, 16'd14, 1);
        wait_ov(0, n);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_out_valid", ov[0], 1);
            chk("bp_result", rs[0], 7);
            chk("bp_in_ready", ir[0], 0);
        end
        @(negedge clk) ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", ov[0], 0);
        chk("bp_release_in_ready", ir[0], 1);

        issue(0, 16'd200, 16'd3, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("clr_busy_before", bz[0], 1);
        clr[0] = 1'b1;
        @(posedge clk);
        #1 clr[0] = 1'b0;
        chk("clr_in_ready", ir[0], 1);
        chk("clr_busy", bz[0], 0);
        chk("clr_result_kept", rs[0], 7);
        repeat (5) @(posedge clk);
        #1 chk("clr_no_out_valid", ov[0], 0);
        issue(0, 16'd21, 16'd14, 1);
        wait_ov(0, n);
        chk("after_clr_result", rs[0], 7);

        issue(0, 16'd200, 16'd3, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", bz[0], 0);
        chk("arst_in_ready", ir[0], 1);
        chk("arst_out_valid", ov[0], 0);
        chk("arst_result", rs[0], 0);
        chk("arst_cycles", cy[0], 0);
        @(negedge clk) rst_n = 1'b1;

        rnd_ready = 1'b1;
        for (int v = 0; v < 50; v++) begin
            logic [15:0] a, b;
            a = (($urandom % 8) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
            b = 16'($urandom_range(1, 300));
            issue(0, a, b, 1);
            a = 16'($urandom);
            b = (($urandom % 10) == 0) ? 16'd0 : 16'($urandom);
            issue(1, a, b, 1);
            a = 16'($urandom_range(0, 255));
            b = 16'($urandom_range(1, 255));
            issue(2, a, b, 1);
        end
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", q0.size() + q1.size() + q2.size(), 0);
        rnd_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
